// File: rtl/divisor_pkg.sv
// Shared constants and helpers for the programmable multi-channel divider.
package divisor_pkg;

    typedef enum logic {
        MODO_CUADRADA = 1'b0,
        MODO_PULSO    = 1'b1
    } modo_t;

    localparam int unsigned DIV_MIN = 2;

    function automatic int unsigned clamp_div(input int unsigned n);
        return (n < DIV_MIN) ? DIV_MIN : n;
    endfunction

endpackage

// File: rtl/divisor_frecuencia_prog_if.sv
// Control/status bundle of the programmable divider: load port, global controls, per-channel outputs.
interface divisor_frecuencia_prog_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_CH = 2
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              en;
    logic              sync;
    logic              load;
    logic [CH_W-1:0]   ch_sel;
    logic [WIDTH-1:0]  div_in;
    logic              mode_in;
    logic              load_ack;
    logic              load_err;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] salida;
    logic [NUM_CH-1:0] tick;

    modport master (
        output en, sync, load, ch_sel, div_in, mode_in,
        input  load_ack, load_err, pend, salida, tick
    );

    modport slave (
        input  en, sync, load, ch_sel, div_in, mode_in,
        output load_ack, load_err, pend, salida, tick
    );

endinterface

// File: rtl/divisor_canal.sv
// One divider channel: period counter, active/shadow divisor and mode, registered output and tick.
module divisor_canal
    import divisor_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DIV_RESET = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             wr_mode,
    output logic             salida,
    output logic             tick,
    output logic             pend
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(clamp_div(DIV_RESET));
    localparam logic [WIDTH-1:0] DIV_LO  = WIDTH'(DIV_MIN);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    modo_t            mode_q, mode_d;
    modo_t            shm_q, shm_d;
    logic             pend_q, pend_d;
    logic             sal_q, sal_d;

    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] thr;
    logic             wrap;

    assign last = div_q - WIDTH'(1);
    assign thr  = div_q - (div_q >> 1);
    assign wrap = en && (cnt_q == last);

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        sh_d   = sh_q;
        mode_d = mode_q;
        shm_d  = shm_q;
        pend_d = pend_q;
        sal_d  = sal_q;

        if (sync) begin
            cnt_d = '0;
            sal_d = 1'b0;
            if (pend_q) begin
                div_d = sh_q;
                mode_d = shm_q;
            end
            pend_d = 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt_d = '0;
                if (pend_q) begin
                    div_d = sh_q;
                    mode_d = shm_q;
                end
                pend_d = 1'b0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            // Old N/mode suffice: at a wrap the new count is 0, which is low for any N>=2.
            if (mode_q == MODO_PULSO) begin
                sal_d = (cnt_d == last);
            end else begin
                sal_d = (cnt_d >= thr);
            end
        end

        // Load capture after wrap/sync so a same-edge write waits for the next boundary.
        if (wr) begin
            sh_d   = (wr_div < DIV_LO) ? DIV_LO : wr_div;
            shm_d  = modo_t'(wr_mode);
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= DIV_RST;
            sh_q   <= DIV_RST;
            mode_q <= MODO_CUADRADA;
            shm_q  <= MODO_CUADRADA;
            pend_q <= 1'b0;
            sal_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            sh_q   <= sh_d;
            mode_q <= mode_d;
            shm_q  <= shm_d;
            pend_q <= pend_d;
            sal_q  <= sal_d;
        end
    end

    assign tick   = wrap;
    assign salida = sal_q;
    assign pend   = pend_q;

endmodule

// File: rtl/divisor_frecuencia_prog.sv
// Multi-channel programmable divider top: channel select decode, load handshake, channel array.
module divisor_frecuencia_prog
    import divisor_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DIV_RESET = 64
) (
    input logic                      clk,
    input logic                      reset,
    divisor_frecuencia_prog_if.slave dif
);

    logic              sel_ok;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] sal;
    logic [NUM_CH-1:0] tck;
    logic [NUM_CH-1:0] pnd;

    assign sel_ok = (32'(dif.ch_sel) < NUM_CH);

    always_comb begin
        ack_d = dif.load && sel_ok;
        err_d = dif.load && !sel_ok;
        wr    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr[i] = dif.load && (32'(dif.ch_sel) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_canal
        divisor_canal #(
            .WIDTH     (WIDTH),
            .DIV_RESET (DIV_RESET)
        ) u_canal (
            .clk     (clk),
            .reset   (reset),
            .en      (dif.en),
            .sync    (dif.sync),
            .wr      (wr[g]),
            .wr_div  (dif.div_in),
            .wr_mode (dif.mode_in),
            .salida  (sal[g]),
            .tick    (tck[g]),
            .pend    (pnd[g])
        );
    end

    assign dif.load_ack = ack_q;
    assign dif.load_err = err_q;
    assign dif.salida   = sal;
    assign dif.tick     = tck;
    assign dif.pend     = pnd;

endmodule
